ram_rmw_ctrl: RTL

- Parametrised synchronous data RAM with a request/valid handshake and registered output.
- Adds optional memory clear after reset and atomic increment/decrement (read-modify-write) of a cell.
- Serves as the data-tape memory of the DPC core: the Brainfuck "+", "-", "," and "." ops map onto single requests, and the Zero flag drives "[" and "]".

---
 rtl/ram_rmw_ctrl_pkg.sv | 26 ++
 rtl/ram_rmw_ctrl_if.sv | 31 +++
 rtl/ram_rmw_ctrl_array.sv | 33 +++
 rtl/ram_rmw_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ram_rmw_ctrl_pkg.sv
// ram_rmw_ctrl_pkg
//   Shared types for the data-tape RAM controller: request opcodes and the
//   controller state encoding.
package ram_rmw_ctrl_pkg;

  // Request opcodes carried on the Op field of the request bus.
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INC   = 2'd2,
    OP_DEC   = 2'd3
  } op_e;

  // Controller states.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RMW   = 2'd2
  } state_e;

  // INC and DEC are the two opcodes that need a read-modify-write pass.
  function automatic logic is_rmw_op(input op_e op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/ram_rmw_ctrl_if.sv
// ram_rmw_ctrl_if
//   Request/result bus of the data-tape RAM.
//   Req/Op/Address/DataIn : request side, driven by the master
//   Ready                 : controller can accept a request this cycle
//   Valid/DataOut/Zero    : result side, driven by the controller
interface ram_rmw_ctrl_if #(
  parameter int AddressSize = 16,
  parameter int DataSize    = 8
);
  import ram_rmw_ctrl_pkg::*;

  logic                   Req;
  op_e                    Op;
  logic [AddressSize-1:0] Address;
  logic [DataSize-1:0]    DataIn;
  logic                   Ready;
  logic                   Valid;
  logic [DataSize-1:0]    DataOut;
  logic                   Zero;

  modport master (
    output Req, Op, Address, DataIn,
    input  Ready, Valid, DataOut, Zero
  );

  modport slave (
    input  Req, Op, Address, DataIn,
    output Ready, Valid, DataOut, Zero
  );

endinterface

// File: rtl/ram_rmw_ctrl_array.sv
// ram_sp_array
//   Plain single-port synchronous RAM: write on posedge when we, registered
//   read on posedge when re. The read register holds its value while re=0.
//   Ports: Clk, we, re, addr, wdata, rdata.
module ram_sp_array #(
  parameter int AddressSize = 16,
  parameter int DataSize    = 8
) (
  input  logic                   Clk,
  input  logic                   we,
  input  logic                   re,
  input  logic [AddressSize-1:0] addr,
  input  logic [DataSize-1:0]    wdata,
  output logic [DataSize-1:0]    rdata
);
  localparam int Depth = 2 ** AddressSize;

  logic [DataSize-1:0] mem [0:Depth-1];
  logic [DataSize-1:0] rdata_reg;

  // No reset: the array and its read register map onto block RAM.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl
//   Data-tape RAM with request/valid handshake, optional clear sweep after
//   reset and atomic INC/DEC (read-modify-write) of a cell.
//   Ports:
//     Clk  : clock, all state changes on posedge
//     Rst  : asynchronous active-high reset
//     bus  : slave side of ram_rmw_ctrl_if (Req/Op/Address/DataIn in,
//            Ready/Valid/DataOut/Zero out)
module ram_rmw_ctrl
  import ram_rmw_ctrl_pkg::*;
#(
  parameter int                   AddressSize  = 16,
  parameter int                   DataSize     = 8,
  parameter bit                   ClearOnReset = 1'b1,
  parameter logic [DataSize-1:0]  ClearValue   = '0
) (
  input logic           Clk,
  input logic           Rst,
  ram_rmw_ctrl_if.slave bus
);

  localparam state_e ResetState = ClearOnReset ? CLEAR : IDLE;

  state_e                 state_reg, state_next;
  logic [AddressSize-1:0] clr_cnt_reg;
  logic [AddressSize-1:0] addr_reg;
  logic                   dec_reg;
  logic                   valid_reg;
  logic                   src_ram_reg;   // 1: DataOut comes straight from the RAM read register
  logic [DataSize-1:0]    hold_reg;      // write echo / RMW result / frozen output

  logic                   ram_we;
  logic                   ram_re;
  logic [AddressSize-1:0] ram_addr;
  logic [DataSize-1:0]    ram_wdata;
  logic [DataSize-1:0]    ram_rdata;

  logic [DataSize-1:0]    rmw_result;
  logic [DataSize-1:0]    data_out;
  logic                   accept;

  // In RMW the RAM read register still holds the cell captured at accept.
  // Arithmetic is DataSize bits wide, so the carry/borrow drops off.
  assign rmw_result = dec_reg ? (ram_rdata - DataSize'(1)) : (ram_rdata + DataSize'(1));

  assign accept = bus.Req && (state_reg == IDLE);

  ram_sp_array #(
    .AddressSize (AddressSize),
    .DataSize    (DataSize)
  ) u_array (
    .Clk   (Clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= ResetState;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and RAM port control.
  always_comb begin
    state_next = state_reg;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = bus.Address;
    ram_wdata  = bus.DataIn;
    case (state_reg)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_reg;
        ram_wdata = ClearValue;
        // Terminal detection on the all-ones address keeps the counter
        // AddressSize bits wide.
        if (clr_cnt_reg == '1) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (bus.Req) begin
          case (bus.Op)
            OP_READ:  ram_re = 1'b1;
            OP_WRITE: ram_we = 1'b1;
            OP_INC,
            OP_DEC: begin
              ram_re     = 1'b1;
              state_next = RMW;
            end
            default: ;
          endcase
        end
      end
      RMW: begin
        ram_we     = 1'b1;
        ram_addr   = addr_reg;
        ram_wdata  = rmw_result;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: clear counter, RMW capture and result registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      clr_cnt_reg <= '0;
      addr_reg    <= '0;
      dec_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      src_ram_reg <= 1'b0;
      hold_reg    <= '0;
    end else begin
      valid_reg <= 1'b0;
      if (state_reg == CLEAR) begin
        clr_cnt_reg <= clr_cnt_reg + AddressSize'(1);
      end
      if (accept) begin
        if (is_rmw_op(bus.Op)) begin
          addr_reg    <= bus.Address;
          dec_reg     <= (bus.Op == OP_DEC);
          // The RAM read register is about to be overwritten by the
          // capture, so freeze the visible result until the RMW completes.
          hold_reg    <= data_out;
          src_ram_reg <= 1'b0;
        end else if (bus.Op == OP_WRITE) begin
          valid_reg   <= 1'b1;
          hold_reg    <= bus.DataIn;
          src_ram_reg <= 1'b0;
        end else begin
          valid_reg   <= 1'b1;
          src_ram_reg <= 1'b1;
        end
      end
      if (state_reg == RMW) begin
        valid_reg   <= 1'b1;
        hold_reg    <= rmw_result;
        src_ram_reg <= 1'b0;
      end
    end
  end

  assign data_out    = src_ram_reg ? ram_rdata : hold_reg;
  assign bus.DataOut = data_out;
  assign bus.Zero    = (data_out == '0);
  assign bus.Valid   = valid_reg;
  assign bus.Ready   = (state_reg == IDLE);

endmodule
